// File: rtl/ahb_out_arb_param.sv
// Output-stage arbiter for the AHB bus matrix: picks which input stage drives the shared slave port.
// Round-robin or fixed priority with burst/lock hold; grant, no_port and change pulse are registered.
module ahb_out_arb_param #(
  parameter int NUM_PORTS   = 4,
  parameter int PORT_W      = 2,
  parameter int ARB_MODE    = 0,
  parameter int INCR_HOLD   = 4,
  parameter int EARLY_LIMIT = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_change
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [3:0]        burst_remain, next_remain;
  logic              burst_hold, next_hold;
  logic [1:0]        early_cnt, next_early;
  logic [PORT_W-1:0] next_port;
  logic              next_no_port;

  logic              any_found, above_found, below_found;
  logic [PORT_W-1:0] any_idx, above_idx, below_idx;

  // Burst tracking: hold drops in the address phase of the final beat.
  always_comb begin
    next_remain = burst_remain;
    next_hold   = burst_hold;
    if (!HSELM || HTRANSM == TR_IDLE) begin
      next_remain = 4'd0;
      next_hold   = 1'b0;
    end else if (HTRANSM == TR_NONSEQ) begin
      case (HBURSTM)
        3'd0: begin
          next_remain = 4'd0;
          next_hold   = 1'b0;
        end
        3'd1: begin
          if (early_cnt == 2'(EARLY_LIMIT)) begin
            next_remain = 4'd0;
            next_hold   = 1'b0;
          end else begin
            next_remain = 4'(INCR_HOLD - 2);
            next_hold   = 1'b1;
          end
        end
        3'd2, 3'd3: begin
          next_remain = 4'd2;
          next_hold   = 1'b1;
        end
        3'd4, 3'd5: begin
          next_remain = 4'd6;
          next_hold   = 1'b1;
        end
        default: begin
          next_remain = 4'd14;
          next_hold   = 1'b1;
        end
      endcase
    end else if (HTRANSM == TR_SEQ) begin
      if (burst_remain == 4'd0) next_hold = 1'b0;
      else next_remain = burst_remain - 4'd1;
    end
  end

  // A NONSEQ arriving while still held means the previous INCR was cut short.
  always_comb begin
    if (!next_hold) next_early = 2'd0;
    else if (burst_hold && HTRANSM == TR_NONSEQ)
      next_early = (early_cnt == 2'd3) ? 2'd3 : early_cnt + 2'd1;
    else next_early = early_cnt;
  end

  always_comb begin
    any_found   = 1'b0;
    any_idx     = '0;
    above_found = 1'b0;
    above_idx   = '0;
    below_found = 1'b0;
    below_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) begin
        if (!any_found) begin
          any_found = 1'b1;
          any_idx   = PORT_W'(i);
        end
        if (!above_found && PORT_W'(i) > addr_in_port) begin
          above_found = 1'b1;
          above_idx   = PORT_W'(i);
        end
        if (!below_found && PORT_W'(i) < addr_in_port) begin
          below_found = 1'b1;
          below_idx   = PORT_W'(i);
        end
      end
    end
  end

  // The current owner's req is ignored; it keeps the port only through HSELM.
  always_comb begin
    next_port    = addr_in_port;
    next_no_port = no_port;
    if (!(HMASTLOCKM || next_hold)) begin
      if (no_port) begin
        if (any_found) begin
          next_port    = any_idx;
          next_no_port = 1'b0;
        end
      end else if (ARB_MODE == 0) begin
        if (above_found) next_port = above_idx;
        else if (below_found) next_port = below_idx;
        else if (!HSELM) next_no_port = 1'b1;
      end else begin
        if (below_found) next_port = below_idx;
        else if (HSELM) next_port = addr_in_port;
        else if (above_found) next_port = above_idx;
        else next_no_port = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      arb_change   <= 1'b0;
      burst_remain <= 4'd0;
      burst_hold   <= 1'b0;
      early_cnt    <= 2'd0;
    end else begin
      arb_change <= 1'b0;
      if (HREADYM) begin
        addr_in_port <= next_port;
        no_port      <= next_no_port;
        arb_change   <= (next_port != addr_in_port) || (next_no_port != no_port);
        burst_remain <= next_remain;
        burst_hold   <= next_hold;
        early_cnt    <= next_early;
      end
    end
  end

  grant_in_range: assert property (@(posedge HCLK) disable iff (HRESET)
    int'(addr_in_port) < NUM_PORTS);

endmodule

// File: tb/tb_ahb_out_arb_param.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and checks both
// against a rule-level reference model every cycle.
module tb_ahb_out_arb_param;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int INCR_HOLD = 4;
  localparam int EARLY_LIMIT = 1;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic [NP-1:0] req = '0;
  logic          hreadym = 1'b1;
  logic          hselm = 1'b0;
  logic [1:0]    htransm = 2'd0;
  logic [2:0]    hburstm = 3'd0;
  logic          hmastlock = 1'b0;
  logic [PW-1:0] addr_rr, addr_fp;
  logic          no_rr, no_fp, chg_rr, chg_fp;

  int n_cmp = 0;
  int n_bad = 0;

  int m_rem, m_hold, m_early;
  int m_port[2];
  int m_np[2];
  int m_chg[2];

  always #5 hclk = ~hclk;

  ahb_out_arb_param #(.NUM_PORTS(NP), .PORT_W(PW), .ARB_MODE(0),
                      .INCR_HOLD(INCR_HOLD), .EARLY_LIMIT(EARLY_LIMIT)) u_rr (
    .HCLK(hclk), .HRESET(hreset), .req(req), .HREADYM(hreadym), .HSELM(hselm),
    .HTRANSM(htransm), .HBURSTM(hburstm), .HMASTLOCKM(hmastlock),
    .addr_in_port(addr_rr), .no_port(no_rr), .arb_change(chg_rr));

  ahb_out_arb_param #(.NUM_PORTS(NP), .PORT_W(PW), .ARB_MODE(1),
                      .INCR_HOLD(INCR_HOLD), .EARLY_LIMIT(EARLY_LIMIT)) u_fp (
    .HCLK(hclk), .HRESET(hreset), .req(req), .HREADYM(hreadym), .HSELM(hselm),
    .HTRANSM(htransm), .HBURSTM(hburstm), .HMASTLOCKM(hmastlock),
    .addr_in_port(addr_fp), .no_port(no_fp), .arb_change(chg_fp));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int burst_beats(input int hb);
    if (hb == 0) return 1;
    if (hb == 1) return 0;
    return 4 << ((hb - 2) / 2);
  endfunction

  // Decide the next owner for one arbiter given whether the port is held.
  task automatic arb_pick(input int mode, input int held, output int ng, output int nn);
    int p, best;
    p  = m_port[mode];
    ng = p;
    nn = m_np[mode];
    if (hmastlock || held != 0) return;
    if (m_np[mode] != 0) begin
      for (int j = 0; j < NP; j++)
        if (req[j]) begin
          ng = j;
          nn = 0;
          return;
        end
      return;
    end
    if (mode == 0) begin
      for (int k = 1; k < NP; k++)
        if (req[(p + k) % NP]) begin
          ng = (p + k) % NP;
          return;
        end
      if (!hselm) nn = 1;
    end else begin
      best = -1;
      for (int j = NP - 1; j >= 0; j--)
        if (j != p && req[j]) best = j;
      if (best >= 0 && best < p) ng = best;
      else if (hselm) ng = p;
      else if (best >= 0) ng = best;
      else nn = 1;
    end
  endtask

  task automatic model_update();
    int nrem, nhold, nearly, beats, ng, nn;
    if (hreset) begin
      m_rem = 0; m_hold = 0; m_early = 0;
      for (int m = 0; m < 2; m++) begin
        m_port[m] = 0; m_np[m] = 1; m_chg[m] = 0;
      end
      return;
    end
    if (!hreadym) begin
      m_chg[0] = 0; m_chg[1] = 0;
      return;
    end
    nrem = m_rem;
    nhold = m_hold;
    if (!hselm || htransm == 2'd0) begin
      nrem = 0; nhold = 0;
    end else if (htransm == 2'd2) begin
      beats = burst_beats(int'(hburstm));
      if (beats == 1) begin
        nrem = 0; nhold = 0;
      end else if (beats == 0) begin
        if (m_early == EARLY_LIMIT) begin
          nrem = 0; nhold = 0;
        end else begin
          nrem = INCR_HOLD - 2; nhold = 1;
        end
      end else begin
        nrem = beats - 2; nhold = 1;
      end
    end else if (htransm == 2'd3) begin
      if (m_rem == 0) nhold = 0;
      else nrem = m_rem - 1;
    end
    if (nhold == 0) nearly = 0;
    else if (m_hold != 0 && htransm == 2'd2) nearly = (m_early >= 3) ? 3 : m_early + 1;
    else nearly = m_early;
    for (int m = 0; m < 2; m++) begin
      arb_pick(m, nhold, ng, nn);
      m_chg[m] = (ng != m_port[m] || nn != m_np[m]) ? 1 : 0;
      m_port[m] = ng;
      m_np[m] = nn;
    end
    m_rem = nrem; m_hold = nhold; m_early = nearly;
  endtask

  task automatic tick();
    @(posedge hclk);
    model_update();
    #1;
    chk("rr_addr", int'(addr_rr), m_port[0]);
    chk("rr_no_port", int'(no_rr), m_np[0]);
    chk("rr_change", int'(chg_rr), m_chg[0]);
    chk("fp_addr", int'(addr_fp), m_port[1]);
    chk("fp_no_port", int'(no_fp), m_np[1]);
    chk("fp_change", int'(chg_fp), m_chg[1]);
  endtask

  task automatic set_idle();
    hreset = 1'b0; req = '0; hreadym = 1'b1; hselm = 1'b0;
    htransm = 2'd0; hburstm = 3'd0; hmastlock = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    hreset = 1'b1;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  initial begin
    // Reset
    do_reset();
    chk("reset_no_port", int'(no_rr), 1);
    chk("reset_addr", int'(addr_rr), 0);
    chk("reset_change", int'(chg_rr), 0);

    // Round-robin wrap from port 3 to port 0
    req = 4'b1000; tick();
    chk("wrap_setup", int'(addr_rr), 3);
    req = 4'b0011; hselm = 1'b0; tick();
    chk("wrap_addr", int'(addr_rr), 0);
    chk("wrap_pulse", int'(chg_rr), 1);
    req = 4'b0000; hselm = 1'b1; tick();
    chk("wrap_pulse_end", int'(chg_rr), 0);

    // INCR8 from port 1 with port 2 requesting throughout
    req = 4'b0010; hselm = 1'b0; tick();
    chk("incr8_setup", int'(addr_rr), 1);
    req = 4'b0100; hselm = 1'b1; htransm = 2'd2; hburstm = 3'd5; tick();
    htransm = 2'd3;
    for (int i = 0; i < 6; i++) tick();
    chk("incr8_held", int'(addr_rr), 1);
    tick();
    chk("incr8_release", int'(addr_rr), 2);

    // Back-to-back short INCR bursts from port 0
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0010; hselm = 1'b1; hburstm = 3'd1;
    htransm = 2'd2; tick();
    chk("short_incr_first", int'(addr_rr), 0);
    for (int b = 0; b < 2; b++) begin
      htransm = 2'd3; tick();
      htransm = 2'd2; tick();
    end
    chk("short_incr_moved", int'(addr_rr), 1);

    // Locked transfer on port 2
    do_reset();
    req = 4'b0100; tick();
    hmastlock = 1'b1; hselm = 1'b1; req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      htransm = 2'($urandom_range(0, 3));
      tick();
      chk("lock_addr", int'(addr_rr), 2);
      chk("lock_change", int'(chg_rr), 0);
    end

    // Ready low freezes grant; then fixed priority pulls to the lower port
    do_reset();
    req = 4'b1000; tick();
    hreadym = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = NP'($urandom_range(0, 15));
      tick();
      chk("frozen_addr", int'(addr_fp), 3);
      chk("frozen_no_port", int'(no_fp), 0);
    end
    hreadym = 1'b1; hselm = 1'b1; htransm = 2'd0; req = 4'b0010; tick();
    chk("fp_pull_low", int'(addr_fp), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      hreset    = ($urandom_range(0, 99) == 0);
      req       = NP'($urandom_range(0, 15));
      hreadym   = ($urandom_range(0, 3) != 0);
      hselm     = ($urandom_range(0, 4) != 0);
      htransm   = 2'($urandom_range(0, 3));
      hburstm   = 3'($urandom_range(0, 7));
      hmastlock = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
